// File: rtl/timer_pkg.sv
// Shared types and limits for the hh:mm:ss timekeeper.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2,
        EXPIRED  = 2'd3
    } state_e;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

endpackage

// File: rtl/tick_gen.sv
// One-second prescaler: tick_o is high on the edge where the count wraps,
// so the consumer can advance its state on that same edge.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hms_timer_ctrl.sv
// hh:mm:ss up/down timekeeper with start/stop control, clamped load,
// expiry on reaching zero when counting down, and wrap/tick pulses.
module hms_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int HOUR_MAX = 23,
    parameter int CNT_W    = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] hora,
    input  logic [CNT_W-1:0] min,
    input  logic [CNT_W-1:0] sec,
    input  logic             start,
    input  logic             dir,
    input  logic             stop,
    output logic [CNT_W-1:0] hora_left,
    output logic [CNT_W-1:0] min_left,
    output logic [CNT_W-1:0] sec_left,
    output logic             tick,
    output logic             wrap,
    output logic             expired,
    output logic             running
);

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(HOUR_MAX);
    localparam logic [CNT_W-1:0] M_MAX = CNT_W'(MIN_MAX);
    localparam logic [CNT_W-1:0] S_MAX = CNT_W'(SEC_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] hora_q, hora_d, min_q, min_d, sec_q, sec_d;
    logic             tick_q, tick_d, wrap_q, wrap_d;
    logic             run_w, pre_clr, step;

    assign run_w   = (state_q == RUN_UP) || (state_q == RUN_DOWN);
    // Any accepted control pulse restarts the second from zero.
    assign pre_clr = load || stop || (start && (state_q == IDLE));

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clock  (clock),
        .reset  (reset),
        .en     (run_w),
        .clr    (pre_clr),
        .tick_o (step)
    );

    always_comb begin
        state_d = state_q;
        hora_d  = hora_q;
        min_d   = min_q;
        sec_d   = sec_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        if (load) begin
            hora_d  = (hora > H_MAX) ? H_MAX : hora;
            min_d   = (min > M_MAX) ? M_MAX : min;
            sec_d   = (sec > S_MAX) ? S_MAX : sec;
            state_d = IDLE;
        end else if (stop) begin
            if (run_w) state_d = IDLE;
        end else if (start) begin
            if (state_q == IDLE) begin
                if (!dir) begin
                    state_d = RUN_UP;
                end else if (hora_q == '0 && min_q == '0 && sec_q == '0) begin
                    state_d = EXPIRED;
                end else begin
                    state_d = RUN_DOWN;
                end
            end
        end else if (step) begin
            tick_d = 1'b1;
            if (state_q == RUN_UP) begin
                if (sec_q == S_MAX) begin
                    sec_d = '0;
                    if (min_q == M_MAX) begin
                        min_d = '0;
                        if (hora_q == H_MAX) begin
                            hora_d = '0;
                            wrap_d = 1'b1;
                        end else begin
                            hora_d = hora_q + 1'b1;
                        end
                    end else begin
                        min_d = min_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                if (sec_q == '0) begin
                    sec_d = S_MAX;
                    if (min_q == '0) begin
                        min_d  = M_MAX;
                        hora_d = hora_q - 1'b1;
                    end else begin
                        min_d = min_q - 1'b1;
                    end
                end else begin
                    sec_d = sec_q - 1'b1;
                end
                if (hora_d == '0 && min_d == '0 && sec_d == '0) state_d = EXPIRED;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            hora_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hora_q  <= hora_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign hora_left = hora_q;
    assign min_left  = min_q;
    assign sec_left  = sec_q;
    assign tick      = tick_q;
    assign wrap      = wrap_q;
    assign expired   = (state_q == EXPIRED);
    assign running   = run_w;

endmodule

// File: tb/tb_hms_timer_ctrl.sv
// Directed bench for hms_timer_ctrl: two instances (24 h and 12 h) share inputs.
module tb_hms_timer_ctrl;

    localparam int W = 7;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         load  = 1'b0;
    logic [W-1:0] hora  = '0;
    logic [W-1:0] min   = '0;
    logic [W-1:0] sec   = '0;
    logic         start = 1'b0;
    logic         dir   = 1'b0;
    logic         stop  = 1'b0;

    logic [W-1:0] a_h, a_m, a_s, b_h, b_m, b_s;
    logic         a_tick, a_wrap, a_exp, a_run;
    logic         b_tick, b_wrap, b_exp, b_run;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    hms_timer_ctrl #(.TICK_DIV(4), .HOUR_MAX(23), .CNT_W(W)) u_dut24 (
        .clock(clock), .reset(reset), .load(load), .hora(hora), .min(min), .sec(sec),
        .start(start), .dir(dir), .stop(stop),
        .hora_left(a_h), .min_left(a_m), .sec_left(a_s),
        .tick(a_tick), .wrap(a_wrap), .expired(a_exp), .running(a_run)
    );

    hms_timer_ctrl #(.TICK_DIV(4), .HOUR_MAX(11), .CNT_W(W)) u_dut12 (
        .clock(clock), .reset(reset), .load(load), .hora(hora), .min(min), .sec(sec),
        .start(start), .dir(dir), .stop(stop),
        .hora_left(b_h), .min_left(b_m), .sec_left(b_s),
        .tick(b_tick), .wrap(b_wrap), .expired(b_exp), .running(b_run)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Time packed as hh*10000 + mm*100 + ss for readable reports.
    task automatic check_time(input string tag, input int h, input int m, input int s);
        check(tag, 32'(a_h) * 10000 + 32'(a_m) * 100 + 32'(a_s), 32'(h * 10000 + m * 100 + s));
    endtask

    task automatic do_load(input int h, input int m, input int s);
        hora = W'(h); min = W'(m); sec = W'(s); load = 1'b1;
        cyc(1);
        load = 1'b0;
    endtask

    task automatic do_start(input logic d);
        dir = d; start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        check_time("reset_time", 0, 0, 0);
        check("reset_flags", {a_tick, a_wrap, a_exp, a_run}, 0);

        // 1: up count across a minute boundary
        do_load(0, 0, 58);
        do_start(1'b0);
        check("t1_running", a_run, 1);
        cyc(3);
        check_time("t1_before", 0, 0, 58);
        check("t1_no_tick", a_tick, 0);
        cyc(1);
        check_time("t1_first", 0, 0, 59);
        check("t1_tick", a_tick, 1);
        check("t1_wrap0", a_wrap, 0);
        cyc(1);
        check("t1_tick_pulse", a_tick, 0);
        cyc(3);
        check_time("t1_second", 0, 1, 0);
        check("t1_tick2", a_tick, 1);

        // 2: full-day wrap
        do_load(23, 59, 59);
        do_start(1'b0);
        cyc(4);
        check_time("t2_wrap_time", 0, 0, 0);
        check("t2_wrap_tick", {a_wrap, a_tick}, 3);
        check("t2_still_run", a_run, 1);
        cyc(4);
        check_time("t2_after", 0, 0, 1);
        check("t2_wrap_gone", a_wrap, 0);

        // 3: down count to expiry
        do_load(0, 1, 0);
        do_start(1'b1);
        cyc(4);
        check_time("t3_first", 0, 0, 59);
        cyc(4 * 58);
        check_time("t3_one_left", 0, 0, 1);
        check("t3_not_exp", a_exp, 0);
        cyc(4);
        check_time("t3_zero", 0, 0, 0);
        check("t3_exp_flags", {a_exp, a_run, a_tick}, 3'b101);
        do_start(1'b0);
        cyc(8);
        check("t3_start_ignored", {a_exp, a_run}, 2'b10);
        check_time("t3_held", 0, 0, 0);
        do_load(0, 0, 5);
        check("t3_load_clears", a_exp, 0);
        check_time("t3_loaded", 0, 0, 5);

        // 4: clamping, and down-start at zero
        do_load(30, 75, 60);
        check("t4_clamp12", 32'(b_h) * 10000 + 32'(b_m) * 100 + 32'(b_s), 115959);
        check_time("t4_clamp24", 23, 59, 59);
        do_load(0, 0, 0);
        do_start(1'b1);
        check("t4_exp_now", {b_exp, b_run, b_tick, b_wrap}, 4'b1000);
        check("t4_exp_now24", {a_exp, a_tick}, 2'b10);

        // 5: stop holds time, restart gets a full second
        do_load(0, 0, 10);
        do_start(1'b0);
        cyc(2);
        do_stop();
        check("t5_stopped", {a_run, a_tick}, 0);
        cyc(5);
        check_time("t5_held", 0, 0, 10);
        do_start(1'b0);
        cyc(3);
        check_time("t5_not_yet", 0, 0, 10);
        cyc(1);
        check_time("t5_resumed", 0, 0, 11);
        check("t5_tick", a_tick, 1);

        // 6: pulse priorities and reset mid-run
        hora = 0; min = 0; sec = 20; dir = 1'b0; load = 1'b1; start = 1'b1;
        cyc(1);
        load = 1'b0; start = 1'b0;
        check("t6_load_wins", a_run, 0);
        cyc(6);
        check_time("t6_idle_hold", 0, 0, 20);
        do_start(1'b0);
        cyc(1);
        stop = 1'b1; start = 1'b1;
        cyc(1);
        stop = 1'b0; start = 1'b0;
        check("t6_stop_wins", a_run, 0);
        do_start(1'b0);
        cyc(5);
        check_time("t6_pre_reset", 0, 0, 21);
        reset = 1'b1;
        cyc(1);
        check_time("t6_reset_time", 0, 0, 0);
        check("t6_reset_flags", {a_tick, a_wrap, a_exp, a_run, b_run}, 0);
        reset = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hms_timer_ctrl.md
Name: hms_timer_ctrl

Overview:
Parametrised hh:mm:ss timekeeper, the successor to the fixed 24 h up-counting timer.
- Adds selectable count-up/count-down mode, start/stop control and load-value clamping.
- Adds an expiry flag and wrap/tick pulses; the prescaler divisor and hour limit are parameters.
- Sits between the button/edge-detector front end and the 7-segment display driver.
- Runs entirely in the single `clock` domain, with no derived clock.

Parameters:
- TICK_DIV, 50_000_000: `clock` cycles per one-second tick (≥2).
- HOUR_MAX, 23: highest hour value before up-count wrap (e.g. 23 or 11).
- CNT_W, 7: width of the hour/min/sec fields.

Ports:
- clock, input, 1: single system clock.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: one-cycle pulse; loads hora/min/sec and forces IDLE.
- hora, input, CNT_W: hour load value.
- min, input, CNT_W: minute load value.
- sec, input, CNT_W: second load value.
- start, input, 1: one-cycle pulse; begin counting in the direction given by dir.
- dir, input, 1: 0 = count up, 1 = count down; sampled on start only.
- stop, input, 1: one-cycle pulse; pause, holding the current time.
- hora_left, output, CNT_W: current hour.
- min_left, output, CNT_W: current minute.
- sec_left, output, CNT_W: current second.
- tick, output, 1: one-cycle pulse, coincident with each time update.
- wrap, output, 1: one-cycle pulse when an up-count rolls HOUR_MAX:59:59 to 00:00:00.
- expired, output, 1: level; high in EXPIRED state.
- running, output, 1: level; high in RUN_UP or RUN_DOWN.

Behaviour:
- Reset:
  - Synchronous, active-high.
  - Every output and internal register goes to 0, and the state goes to IDLE.
- States:
  - IDLE: time held, prescaler held at 0.
  - RUN_UP and RUN_DOWN: counting.
  - EXPIRED: time held at 00:00:00, expired=1.
- Priority when pulses coincide: reset > load > stop > start.
- load (any state):
  - Next cycle: hora_left=min(hora,HOUR_MAX), min_left=min(min,59), sec_left=min(sec,59).
  - State goes to IDLE and the prescaler clears.
- start:
  - Honoured in IDLE only; ignored in RUN_UP, RUN_DOWN and EXPIRED (load first).
  - Clears the prescaler to 0.
  - dir=0 → RUN_UP.
  - dir=1 with time ≠ 0 → RUN_DOWN.
  - dir=1 with time == 00:00:00 → EXPIRED next cycle, no tick.
- stop: honoured in RUN_UP/RUN_DOWN → IDLE with the time kept; the prescaler clears, so a resumed start gets a full second.
- Prescaler (RUN states only):
  - Counts 0..TICK_DIV-1.
  - On the edge where it equals TICK_DIV-1 it returns to 0 and the time advances on that same edge.
  - tick is registered high for the following cycle, coincident with the new time value.
  - First advance is visible exactly TICK_DIV cycles after the start pulse cycle.
- Up step:
  - sec+1.
  - sec==59 → sec=0, min+1.
  - min==59 and sec==59 → min=0, hour+1.
  - HOUR_MAX:59:59 → 00:00:00, wrap=1 with tick, state remains RUN_UP.
- Down step:
  - sec-1.
  - sec==0 → sec=59, min-1.
  - min==0 and sec==0 → min=59, hour-1.
  - From 00:00:01 → 00:00:00, tick=1, state → EXPIRED, expired=1 from that cycle.
- EXPIRED is left only by load or reset.
- All arithmetic is in CNT_W bits. Out-of-range values cannot occur after load clamping.
- Reset mid-count abandons the partial second; there is no carry-over.

Decomposition:
- Package timer_pkg:
  - state enum {IDLE, RUN_UP, RUN_DOWN, EXPIRED}.
  - Constants SEC_MAX=59, MIN_MAX=59.
- Sub-module tick_gen (parameter TICK_DIV; ports clock, reset, en, clr, tick_o) implements the prescaler.
- The time-step logic stays in hms_timer_ctrl.

Test Plan:
1. TICK_DIV=4, HOUR_MAX=23; load 00:00:58, start dir=0 → time is 00:00:59 at start+4, 00:01:00 at start+8, one tick per update, wrap=0.
2. Load 23:59:59, start dir=0 → after 4 cycles time is 00:00:00 with wrap=1 and tick=1 in the same cycle; counting continues to 00:00:01.
3. Load 00:01:00, start dir=1 → 00:00:59 after the first tick; continue until 00:00:00 → expired=1, running=0, tick=1 on the final step. A further start is ignored; a load clears expired.
4. Load hora=30, min=75, sec=60 with HOUR_MAX=11 → outputs 11:59:59. Start dir=1 at 00:00:00 → expired=1 the next cycle, no tick.
5. Start up at 00:00:10; stop after 2 cycles → time stays 00:00:10. Restart → next update exactly 4 cycles later, to 00:00:11.
6. load and start in the same cycle → load wins, state IDLE. stop+start in RUN → stop wins. reset asserted mid-run → all outputs 0 on the next edge.
